pipe_stage_fifo: RTL and testbench
==================================

# pipe_stage_fifo

Parametrised elastic pipeline-stage register: the next generation of the fixed MEM/WB latch. It replaces the single enable-gated register with a DEPTH-entry first-word-fall-through queue with a valid/ready handshake on both sides and a synchronous flush. Per-entry PC, instruction and payload are carried alongside. It sits between any two pipeline stages (IF/ID … MEM/WB), so a downstream stall back-pressures upstream without dropping or duplicating an instruction.

## Interface
- DATA_W, 107, stage payload width in bits (control + data fields packed by the instantiating stage).
- DEPTH, 2, number of entries; power of two, ≥ 2.
- CNT_W, derived localparam = $clog2(DEPTH+1), occupancy counter width.

- clk_Stage  in  1  stage clock; all state updates on the falling edge, matching the other pipeline registers.
- rst_Stage  in  1  reset; synchronous, active-high.
- flush_Stage  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry; equals !full.
- in_pc  in  32  PC of the offered instruction.
- in_inst  in  32  instruction word.
- in_data  in  DATA_W  payload.
- out_valid  out  1  head entry present; equals !empty.
- out_ready  in  1  downstream consumes the head this cycle.
- out_pc  out  32  head PC; 0 when empty.
- out_inst  out  32  head instruction; 0 when empty.
- out_data  out  DATA_W  head payload; 0 when empty.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {pc, inst, data}, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits, natural wrap), count register.
- push = in_valid & in_ready & !flush_Stage; pop = out_valid & out_ready & !flush_Stage.
- push only: entry written at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push & pop, neither full nor empty: both pointers advance, count unchanged.
- Full: in_ready = 0, so push is impossible; a pop frees a slot visible only from the next cycle (no same-cycle pass-through on full).
- Empty: out_valid = 0; an out_ready has no effect; no bypass, so new data appears at the output one edge after the push.
- Outputs are combinational reads of the head entry, masked to 0 when empty; this reproduces a bubble (valid=0, all fields 0), identical to the old register's reset state.
- flush_Stage: wr_ptr, rd_ptr and count set to 0; a push or pop offered in the same cycle is ignored; storage contents are not cleared (they are masked).
- Reset: identical to flush, plus every storage entry cleared to 0.
- Precedence: rst_Stage > flush_Stage > push/pop.
- Pointer wrap: wr_ptr/rd_ptr roll from DEPTH−1 to 0; count never exceeds DEPTH or underflows 0 (guaranteed by push/pop gating).

## Timing
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_inst=0, out_data=0, count=0, full=0, empty=1.
- Latency: entry pushed at falling edge N is on out_* with out_valid=1 after edge N (usable the following cycle). Throughput is 1 entry/cycle with out_ready held high.
- in_ready, full, empty and count depend only on registered state (no combinational path from out_ready or in_valid).
- After flush or reset at edge N: out_valid=0 and in_ready=1 from edge N; a push at edge N+1 is accepted.
- Reset asserted mid-stream discards all entries at that edge; nothing in flight is delivered.

## Test plan
- Reset: hold rst_Stage 2 cycles with in_valid=1 → count=0, empty=1, in_ready=1, out_valid=0, out_pc/out_inst/out_data=0.
- Streaming: DEPTH=2, out_ready=1, push PCs 0x00,0x04,0x08 on consecutive cycles → the same PCs appear in order one cycle later each; count stays 1.
- Back-pressure: out_ready=0, push 0x10,0x14,0x18 → first two accepted, full=1, in_ready=0, 0x18 held upstream. Then out_ready=1 → outputs 0x10,0x14,0x18 in order with no duplicate.
- Wrap: DEPTH=4, 10 push/pop cycles with alternating stalls → output order equals input order; count tracks the push−pop difference and never exceeds 4.
- Flush: count=2, assert flush_Stage together with in_valid=1 (PC 0x20) and out_ready=1 → next cycle count=0, out_valid=0, 0x20 is not stored, and the head is not counted as popped.
- Simultaneous: count=1, push 0x30 with pop → count stays 1, out_pc=0x30 next cycle.

Source files
------------

// File: rtl/pipe_stage_fifo_if.sv
// Handshake bundle between an upstream stage, the elastic stage queue and the downstream stage.
interface pipe_stage_fifo_if #(
  parameter int unsigned DATA_W = 107,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  // Environment side: offers entries upstream and consumes them downstream.
  modport master (
    output in_valid, in_pc, in_inst, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_data, count, full, empty
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_inst, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_data, count, full, empty
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry first-word-fall-through queue of
// {pc, inst, data} with valid/ready on both sides, synchronous flush and reset.
// State advances on the falling edge of clk_Stage like the other stage latches.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W = 107,
  parameter int unsigned DEPTH  = 2
) (
  input  logic             clk_Stage,
  input  logic             rst_Stage,
  input  logic             flush_Stage,
  pipe_stage_fifo_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   full_c;
  logic   empty_c;
  logic   push_c;
  logic   pop_c;
  entry_t head_c;

  // Occupancy flags and gated handshakes; flush suppresses both sides.
  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    empty_c = (count_q == '0);
    push_c  = bus.in_valid & ~full_c & ~flush_Stage;
    pop_c   = bus.out_ready & ~empty_c & ~flush_Stage;
  end

  // Next-state: write at tail, advance pointers, track occupancy; flush rewinds.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{pc: bus.in_pc, inst: bus.in_inst, data: bus.in_data};
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop_c) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    if (push_c && !pop_c) begin
      count_d = CNT_W'(count_q + 1'b1);
    end else if (pop_c && !push_c) begin
      count_d = CNT_W'(count_q - 1'b1);
    end
    if (flush_Stage) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers; reset additionally clears the storage array.
  always_ff @(negedge clk_Stage) begin
    if (rst_Stage) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head read, masked to a bubble when the queue is empty.
  always_comb begin
    head_c = empty_c ? '0 : mem_q[rd_ptr_q];
  end

  assign bus.in_ready  = ~full_c;
  assign bus.out_valid = ~empty_c;
  assign bus.out_pc    = head_c.pc;
  assign bus.out_inst  = head_c.inst;
  assign bus.out_data  = head_c.data;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH=2 and DEPTH=4 instances share stimulus and are
// checked every cycle against queue models, plus literal expectations on DEPTH=2.
module tb_pipe_stage_fifo;
  localparam int unsigned DW = 107;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic rst;
  logic flush;

  int checks   = 0;
  int failures = 0;

  ent_t model_q [2][$];
  int   depth_of [2] = '{2, 4};

  pipe_stage_fifo_if #(.DATA_W(DW), .DEPTH(2)) if2 ();
  pipe_stage_fifo_if #(.DATA_W(DW), .DEPTH(4)) if4 ();

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2)) dut2 (
    .clk_Stage(clk), .rst_Stage(rst), .flush_Stage(flush), .bus(if2)
  );
  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(4)) dut4 (
    .clk_Stage(clk), .rst_Stage(rst), .flush_Stage(flush), .bus(if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Compare one instance against its model queue.
  task automatic cmp_inst(input int k, input logic v, input logic r, input logic f,
                          input logic e, input int cnt, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [DW-1:0] data);
    int   sz;
    ent_t h;
    string tag;
    sz  = model_q[k].size();
    tag = (k == 0) ? "d2" : "d4";
    h   = '{pc: '0, inst: '0, data: '0};
    if (sz > 0) h = model_q[k][0];
    chk({tag, ".out_valid"}, 128'(v), 128'(sz > 0));
    chk({tag, ".in_ready"}, 128'(r), 128'(sz < depth_of[k]));
    chk({tag, ".full"}, 128'(f), 128'(sz == depth_of[k]));
    chk({tag, ".empty"}, 128'(e), 128'(sz == 0));
    chk({tag, ".count"}, 128'(cnt), 128'(sz));
    chk({tag, ".out_pc"}, 128'(pc), 128'(h.pc));
    chk({tag, ".out_inst"}, 128'(inst), 128'(h.inst));
    chk({tag, ".out_data"}, 128'(data), 128'(h.data));
  endtask

  task automatic compare_all();
    cmp_inst(0, if2.out_valid, if2.in_ready, if2.full, if2.empty, int'(if2.count),
             if2.out_pc, if2.out_inst, if2.out_data);
    cmp_inst(1, if4.out_valid, if4.in_ready, if4.full, if4.empty, int'(if4.count),
             if4.out_pc, if4.out_inst, if4.out_data);
  endtask

  // One cycle: drive inputs, let the falling edge act, update models, check mid-cycle.
  task automatic step(input logic r, input logic fl, input logic iv, input logic ordy,
                      input logic [31:0] pc);
    ent_t e;
    logic [127:0] rnd;
    bit push [2];
    bit pop  [2];
    rnd    = {$urandom, $urandom, $urandom, $urandom};
    e.pc   = pc;
    e.inst = $urandom;
    e.data = DW'(rnd);
    rst   = r;
    flush = fl;
    if2.in_valid = iv; if2.out_ready = ordy;
    if2.in_pc = e.pc;  if2.in_inst = e.inst; if2.in_data = e.data;
    if4.in_valid = iv; if4.out_ready = ordy;
    if4.in_pc = e.pc;  if4.in_inst = e.inst; if4.in_data = e.data;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r || fl) begin
        model_q[k].delete();
      end else begin
        pop[k]  = (model_q[k].size() > 0) && ordy;
        push[k] = iv && (model_q[k].size() < depth_of[k]);
        if (pop[k])  void'(model_q[k].pop_front());
        if (push[k]) model_q[k].push_back(e);
      end
    end
    @(posedge clk);
    compare_all();
  endtask

  initial begin
    int stall;
    logic [31:0] pc;
    rst = 1'b1;
    flush = 1'b0;

    // Reset held two cycles with an entry offered.
    step(1, 0, 1, 0, 32'h100);
    step(1, 0, 1, 0, 32'h104);
    chk("rst.count", 128'(if2.count), 128'd0);
    chk("rst.empty", 128'(if2.empty), 128'd1);
    chk("rst.in_ready", 128'(if2.in_ready), 128'd1);
    chk("rst.out_valid", 128'(if2.out_valid), 128'd0);
    chk("rst.out_pc", 128'(if2.out_pc), 128'd0);
    chk("rst.out_inst", 128'(if2.out_inst), 128'd0);
    chk("rst.out_data", 128'(if2.out_data), 128'd0);
    chk("rst.full", 128'(if2.full), 128'd0);

    // Streaming at full throughput.
    step(0, 0, 1, 1, 32'h00);
    chk("stream.pc0", 128'(if2.out_pc), 128'h00);
    chk("stream.valid0", 128'(if2.out_valid), 128'd1);
    chk("stream.count0", 128'(if2.count), 128'd1);
    step(0, 0, 1, 1, 32'h04);
    chk("stream.pc1", 128'(if2.out_pc), 128'h04);
    chk("stream.count1", 128'(if2.count), 128'd1);
    step(0, 0, 1, 1, 32'h08);
    chk("stream.pc2", 128'(if2.out_pc), 128'h08);
    chk("stream.count2", 128'(if2.count), 128'd1);
    step(0, 0, 0, 1, 32'h0);
    chk("stream.drain", 128'(if2.out_valid), 128'd0);

    // Back-pressure: third entry held upstream until space frees.
    step(0, 0, 1, 0, 32'h10);
    chk("bp.count1", 128'(if2.count), 128'd1);
    step(0, 0, 1, 0, 32'h14);
    chk("bp.full", 128'(if2.full), 128'd1);
    chk("bp.in_ready", 128'(if2.in_ready), 128'd0);
    chk("bp.head", 128'(if2.out_pc), 128'h10);
    step(0, 0, 1, 0, 32'h18);
    chk("bp.held_count", 128'(if2.count), 128'd2);
    chk("bp.held_head", 128'(if2.out_pc), 128'h10);
    step(0, 0, 1, 1, 32'h18);
    chk("bp.out1", 128'(if2.out_pc), 128'h14);
    chk("bp.no_passthru", 128'(if2.count), 128'd1);
    step(0, 0, 1, 1, 32'h18);
    chk("bp.out2", 128'(if2.out_pc), 128'h18);
    step(0, 0, 0, 1, 32'h0);
    chk("bp.empty", 128'(if2.empty), 128'd1);

    // Flush with a simultaneous push and pop offered.
    step(0, 0, 1, 0, 32'h40);
    step(0, 0, 1, 0, 32'h44);
    chk("fl.pre_count", 128'(if2.count), 128'd2);
    step(0, 1, 1, 1, 32'h20);
    chk("fl.count", 128'(if2.count), 128'd0);
    chk("fl.valid", 128'(if2.out_valid), 128'd0);
    chk("fl.in_ready", 128'(if2.in_ready), 128'd1);
    step(0, 0, 0, 0, 32'h0);
    chk("fl.not_stored", 128'(if2.count), 128'd0);
    step(0, 0, 1, 0, 32'h50);
    chk("fl.push_after", 128'(if2.out_pc), 128'h50);

    // Simultaneous push and pop at count 1.
    step(0, 0, 1, 1, 32'h30);
    chk("sim.count", 128'(if2.count), 128'd1);
    chk("sim.pc", 128'(if2.out_pc), 128'h30);

    // Randomized traffic with stall phases, flushes and mid-stream resets.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      if (((i / 8) % 2) == 1) stall = ($urandom_range(0, 3) != 0) ? 1 : 0;
      else                    stall = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, stall == 0, pc);
      pc = pc + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
